// File: rtl/uart_instr_loader.sv
// 8N1 UART receiver feeding a framed-program loader (A5, N, N little-endian words) into instruction memory.
// Write strobe is registered one cycle after the last byte of a word; no backpressure, the UART line cannot be stalled.
module uart_instr_loader #(
  parameter int F_CLK        = 50_000_000,
  parameter int BAUD         = 921_600,
  parameter int CLK_PER_BIT  = F_CLK / BAUD,
  parameter int INSTR_WIDTH  = 32,
  parameter int INSTR_DEPTH  = 256,
  parameter int ADDR_WIDTH   = $clog2(INSTR_DEPTH),
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic                   wr_en,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [INSTR_WIDTH-1:0] wr_data,
  output logic                   busy,
  output logic                   load_done,
  output logic                   frame_err,
  output logic                   timeout_err
);

  localparam int CW      = $clog2(CLK_PER_BIT);
  localparam int TO_CLKS = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {L_SYNC, L_COUNT, L_DATA} l_state_t;

  rx_state_t rx_state;
  l_state_t  l_state;

  logic          rx_sync1, rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_byte;
  logic          rx_valid, rx_ferr;

  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            byte_idx;
  logic [23:0]           word_q;
  logic [7:0]            count;
  logic [7:0]            words;
  logic                  done_pend;
  logic [TW-1:0]         to_cnt;
  logic                  to_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      rx_sync1 <= uart_rx;
      rx_s     <= rx_sync1;
    end
  end

  // rx_byte doubles as the shift register; it is stable while rx_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == CW'(CLK_PER_BIT / 2 - 1)) begin
            clk_cnt  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == CW'(CLK_PER_BIT - 1)) begin
            clk_cnt <= '0;
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == CW'(CLK_PER_BIT - 1)) begin
            clk_cnt  <= '0;
            rx_valid <= rx_s;
            rx_ferr  <= !rx_s;
            rx_state <= RX_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign to_hit = (to_cnt == TW'(TO_CLKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_state     <= L_SYNC;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      addr        <= '0;
      byte_idx    <= '0;
      word_q      <= '0;
      count       <= '0;
      words       <= '0;
      done_pend   <= 1'b0;
      to_cnt      <= '0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      // Inter-byte timer only counts while the receiver sits idle mid-packet.
      if (l_state == L_SYNC || rx_valid) to_cnt <= '0;
      else if (rx_state == RX_IDLE)      to_cnt <= to_cnt + 1'b1;

      case (l_state)
        L_SYNC: begin
          if (rx_valid && rx_byte == SYNC_BYTE) begin
            busy        <= 1'b1;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            addr        <= '0;
            byte_idx    <= '0;
            words       <= '0;
            done_pend   <= 1'b0;
            l_state     <= L_COUNT;
          end
        end
        L_COUNT, L_DATA: begin
          if (done_pend) begin
            done_pend <= 1'b0;
            load_done <= 1'b1;
            busy      <= 1'b0;
            l_state   <= L_SYNC;
          end else if (rx_ferr) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            l_state   <= L_SYNC;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            l_state     <= L_SYNC;
          end else if (rx_valid) begin
            if (l_state == L_COUNT) begin
              count <= rx_byte;
              if (rx_byte == 8'd0) begin
                load_done <= 1'b1;
                busy      <= 1'b0;
                l_state   <= L_SYNC;
              end else begin
                l_state <= L_DATA;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
              case (byte_idx)
                2'd0: word_q[7:0]   <= rx_byte;
                2'd1: word_q[15:8]  <= rx_byte;
                2'd2: word_q[23:16] <= rx_byte;
                default: begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= {rx_byte, word_q};
                  addr    <= (addr == ADDR_WIDTH'(INSTR_DEPTH - 1)) ? '0 : addr + 1'b1;
                  words   <= words + 8'd1;
                  if (words + 8'd1 == count) done_pend <= 1'b1;
                end
              endcase
            end
          end
        end
        default: l_state <= L_SYNC;
      endcase
    end
  end

endmodule
